// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional abort input `cancel` is present when MD_CANCEL_EN is defined.
module md_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MD_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              is_div_q;
    logic              signed_q;
    logic              abort;

`ifdef MD_CANCEL_EN
    assign abort = cancel;
`else
    assign abort = 1'b0;
`endif

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               a_neg;
    logic               b_neg;
    logic               div_zero;

    // Signed divide runs as unsigned on magnitudes; the quotient sign is the XOR of the
    // operand signs and the remainder follows the dividend. 0x8000_0000 / -1 falls out
    // naturally as quotient 0x8000_0000, remainder 0.
    always_comb begin
        a_neg    = signed_q & a_q[WIDTH-1];
        b_neg    = signed_q & b_q[WIDTH-1];
        a_mag    = a_neg ? -a_q : a_q;
        b_mag    = b_neg ? -b_q : b_q;
        div_zero = (b_q == '0);
        if (div_zero) begin
            q_mag = '0;
            r_mag = '0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem  = a_neg ? -r_mag : r_mag;
        if (signed_q) begin
            prod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            busy     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        case (op)
                            OpMult, OpMultu, OpDiv, OpDivu: begin
                                a_q      <= a;
                                b_q      <= b;
                                is_div_q <= op[1];
                                signed_q <= ~op[0];
                                cnt_q    <= op[1] ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
                                state_q  <= StRun;
                                busy     <= 1'b1;
                            end
                            OpMthi:  hi <= a;
                            OpMtlo:  lo <= a;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    if (abort) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (cnt_q == CntW'(1)) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        if (!is_div_q) begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end else if (!div_zero) begin
                            hi <= rem;
                            lo <= quot;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
            endcase
        end
    end

endmodule
